// File: rtl/sa_mux_pkg.sv
// Shared types and helpers for the round-robin mux funnel family.
package sa_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Index width for an n-entry source field; a single channel still needs one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sa_mux_rr_pipe_if.sv
// Upstream channel bundle plus the registered downstream link of the mux.
interface sa_mux_rr_pipe_if import sa_mux_pkg::*; #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32
);
    localparam int SRC_W = src_width(NUM_IN);

    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [SRC_W-1:0]         out_src;

    // Environment side: drives the channels and the downstream ready.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );

    // Mux side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );

endinterface

// File: rtl/sa_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module sa_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    int               j;
    logic [IDX_W-1:0] cand;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx  = '0;
        j    = 0;
        cand = '0;
        // Walk the offsets from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            j    = (int'(ptr) + k) % N;
            cand = IDX_W'(j);
            if (req[cand]) idx = cand;
        end
    end

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = req[idx] && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/sa_mux_rr_pipe.sv
// N:1 round-robin mux with valid/ready, packet locking on last, and a registered output.
module sa_mux_rr_pipe import sa_mux_pkg::*; #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 32
) (
    input logic              nvdla_core_clk,
    input logic              nvdla_core_rstn,
    sa_mux_rr_pipe_if.slave  bus
);
    localparam int SRC_W = src_width(NUM_IN);

    lock_state_e       state, state_nxt;
    logic              lock;
    logic [SRC_W-1:0]  rr_ptr, lock_src, arb_idx, sel;
    logic [NUM_IN-1:0] arb_gnt, ready;
    logic              slot_free, xfer, sel_last;
    logic [DATA_W-1:0] sel_data;

    logic              out_valid_q, out_last_q;
    logic [DATA_W-1:0] out_data_q;
    logic [SRC_W-1:0]  out_src_q;

    sa_rr_arb #(.N(NUM_IN), .IDX_W(SRC_W)) u_arb (
        .req (bus.in_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign slot_free = !out_valid_q || bus.out_ready;
    assign sel       = lock ? lock_src : arb_idx;
    assign sel_data  = bus.in_data[int'(sel)*DATA_W +: DATA_W];
    assign sel_last  = bus.in_last[sel];

    // While locked only the owning channel may be accepted; reset masks every grant.
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (lock) ready[i] = bus.in_valid[i] && (lock_src == SRC_W'(i));
            else      ready[i] = arb_gnt[i];
        end
        if (!slot_free || !nvdla_core_rstn) ready = '0;
    end

    assign xfer         = |ready;
    assign bus.in_ready = ready;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!nvdla_core_rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_last_q  <= sel_last;
            out_src_q   <= sel;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;

    // Fairness advances per packet: the pointer only moves on a last beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rr_ptr   <= '0;
            lock_src <= '0;
        end else if (xfer) begin
            if (sel_last) rr_ptr <= (sel == SRC_W'(NUM_IN - 1)) ? '0 : sel + SRC_W'(1);
            if (!lock)    lock_src <= sel;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) state <= IDLE;
        else                  state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !sel_last) state_nxt = LOCKED;
            LOCKED:  if (xfer &&  sel_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        lock = (state == LOCKED);
    end

endmodule

// File: tb/tb_sa_mux_rr_pipe.sv
// Directed bench for sa_mux_rr_pipe: reset, streaming, fairness, lock, backpressure, mid-packet reset.
module tb_sa_mux_rr_pipe;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_mux_rr_pipe_if #(.NUM_IN(N), .DATA_W(DW)) bus ();

    sa_mux_rr_pipe #(.NUM_IN(N), .DATA_W(DW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rst_n),
        .bus             (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int ch, input bit v, input bit last, input logic [DW-1:0] d);
        bus.in_valid[ch]         = v;
        bus.in_last[ch]          = last;
        bus.in_data[ch*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        bus.in_valid = '0;
        bus.in_last  = '0;
        bus.in_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Upstream must never abandon a packet once its first beat was accepted.
    logic [N-1:0] open_pkt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) open_pkt <= '0;
        else begin
            for (int i = 0; i < N; i++) begin
                assert (!(open_pkt[i] && !bus.in_valid[i]))
                    else $error("channel %0d dropped valid mid-packet", i);
                if (bus.in_valid[i] && bus.in_ready[i]) open_pkt[i] <= !bus.in_last[i];
            end
        end
    end

    initial begin
        idle_inputs();
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset held with random stimulus.
        for (int c = 0; c < 3; c++) begin
            bus.in_valid = N'($urandom);
            bus.in_last  = N'($urandom);
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_data",  64'(bus.out_data),  64'd0);
            check("rst_out_src",   64'(bus.out_src),   64'd0);
            check("rst_out_last",  64'(bus.out_last),  64'd0);
            check("rst_in_ready",  64'(bus.in_ready),  64'd0);
        end
        idle_inputs();
        #2 rst_n = 1'b1;
        tick();

        // Streaming from channel 2, single-beat packets, one per cycle.
        for (int k = 0; k < 3; k++) begin
            drive(2, 1'b1, 1'b1, DW'(32'h10 + k));
            #1 check("stream_in_ready", 64'(bus.in_ready), 64'b0100);
            tick();
            check("stream_valid", 64'(bus.out_valid), 64'd1);
            check("stream_data",  64'(bus.out_data),  64'(32'h10 + k));
            check("stream_src",   64'(bus.out_src),   64'd2);
        end
        idle_inputs();
        tick();
        check("stream_drain_valid", 64'(bus.out_valid), 64'd0);

        // Fairness: all channels request single-beat packets.
        do_reset();
        for (int ch = 0; ch < N; ch++) drive(ch, 1'b1, 1'b1, DW'(32'hA0 + ch));
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_src",  64'(bus.out_src),  64'(k % N));
            check("rr_data", 64'(bus.out_data), 64'(32'hA0 + (k % N)));
        end
        idle_inputs();

        // Lock: channel 1 three-beat packet while channel 3 waits.
        do_reset();
        drive(3, 1'b1, 1'b1, 32'h33);
        for (int b = 0; b < 3; b++) begin
            drive(1, 1'b1, b == 2, DW'(32'h11 + b));
            #1 check("lock_in_ready", 64'(bus.in_ready), 64'b0010);
            tick();
            check("lock_src",  64'(bus.out_src),  64'd1);
            check("lock_data", 64'(bus.out_data), 64'(32'h11 + b));
            check("lock_last", 64'(bus.out_last), 64'(b == 2));
        end
        drive(1, 1'b0, 1'b0, '0);
        #1 check("unlock_in_ready", 64'(bus.in_ready), 64'b1000);
        tick();
        check("unlock_src",  64'(bus.out_src),  64'd3);
        check("unlock_data", 64'(bus.out_data), 64'h33);
        idle_inputs();

        // Backpressure: output must hold while stalled, then resume without a bubble.
        do_reset();
        drive(0, 1'b1, 1'b1, 32'h55);
        tick();
        check("bp_first_data", 64'(bus.out_data), 64'h55);
        bus.out_ready = 1'b0;
        drive(0, 1'b1, 1'b1, 32'h66);
        for (int k = 0; k < 5; k++) begin
            #1 check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            check("bp_valid", 64'(bus.out_valid), 64'd1);
            check("bp_data",  64'(bus.out_data),  64'h55);
            check("bp_src",   64'(bus.out_src),   64'd0);
            check("bp_last",  64'(bus.out_last),  64'd1);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 64'(bus.in_ready), 64'b0001);
        tick();
        check("bp_next_valid", 64'(bus.out_valid), 64'd1);
        check("bp_next_data",  64'(bus.out_data),  64'h66);
        idle_inputs();

        // Mid-packet reset discards channel 0's packet and frees channel 2.
        do_reset();
        drive(2, 1'b1, 1'b1, 32'h22);
        for (int b = 0; b < 2; b++) begin
            drive(0, 1'b1, 1'b0, DW'(32'h01 + b));
            #1 check("mpr_in_ready", 64'(bus.in_ready), 64'b0001);
            tick();
            check("mpr_data", 64'(bus.out_data), 64'(32'h01 + b));
        end
        rst_n = 1'b0;
        #1;
        check("mpr_rst_valid", 64'(bus.out_valid), 64'd0);
        check("mpr_rst_ready", 64'(bus.in_ready),  64'd0);
        drive(0, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        #1 check("mpr_post_ready", 64'(bus.in_ready), 64'b0100);
        tick();
        check("mpr_post_valid", 64'(bus.out_valid), 64'd1);
        check("mpr_post_src",   64'(bus.out_src),   64'd2);
        check("mpr_post_data",  64'(bus.out_data),  64'h22);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
